// File: rtl/button_event_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_event_arbiter_if                                                  |
// | Valid/ready event port carrying the index of the button that was pressed.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface button_event_arbiter_if #(
  parameter int IDW = 3
);
  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/button_event_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_event_arbiter                                                     |
// | Synchronises and debounces N_BTN push-buttons, latches press events and  |
// | serialises them round-robin onto one valid/ready port. Optional press    |
// | auto-repeat is enabled by defining BTN_REPEAT_EN.                        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module button_event_arbiter #(
  parameter int N_BTN     = 5,
  parameter int TICK_DIV  = 100000,
  parameter int DEB_TICKS = 8,
  parameter int REP_DELAY = 500,
  parameter int REP_RATE  = 100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_BTN-1:0]       btn_raw_i,
  output logic [N_BTN-1:0]       btn_level_o,
  button_event_arbiter_if.master evt,
  output logic                   ovf_o,
  input  logic                   ovf_clr_i
);
  localparam int IDW = $clog2(N_BTN);
  localparam int PW  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int DCW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

  if (N_BTN < 2 || TICK_DIV < 2 || DEB_TICKS < 1 || REP_DELAY < 1 || REP_RATE < 1)
  begin : g_param_check
    $error("button_event_arbiter: illegal parameter value");
  end

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } state_t;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] press_deb, press;
  logic [N_BTN-1:0] grant_vec;
  logic [DCW-1:0]   deb_cnt_q [N_BTN];
  logic [DCW-1:0]   deb_cnt_d [N_BTN];
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic             ovf_q, ovf_d;
  state_t           state_q, state_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic             grant_now;

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  always_comb begin
    level_d   = level_q;
    press_deb = '0;
    for (int i = 0; i < N_BTN; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (tick) begin
        if (sync2_q[i] == level_q[i]) begin
          deb_cnt_d[i] = '0;
        end else if (deb_cnt_q[i] == DCW'(DEB_TICKS - 1)) begin
          level_d[i]   = sync2_q[i];
          deb_cnt_d[i] = '0;
          press_deb[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RCW  = $clog2(RMAX + 1);

  logic [RCW-1:0]   rep_cnt_q [N_BTN];
  logic [RCW-1:0]   rep_cnt_d [N_BTN];
  logic [N_BTN-1:0] rep_first_q, rep_first_d;
  logic [N_BTN-1:0] press_rep;

  // Gating on level_d stops a repeat from firing on the very tick the release is accepted.
  always_comb begin
    rep_first_d = rep_first_q;
    press_rep   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rep_cnt_d[i] = rep_cnt_q[i];
      if (press_deb[i] || !level_d[i]) begin
        rep_cnt_d[i]   = '0;
        rep_first_d[i] = 1'b1;
      end else if (tick) begin
        if (rep_first_q[i] && rep_cnt_q[i] == RCW'(REP_DELAY - 1)) begin
          press_rep[i]   = 1'b1;
          rep_cnt_d[i]   = '0;
          rep_first_d[i] = 1'b0;
        end else if (!rep_first_q[i] && rep_cnt_q[i] == RCW'(REP_RATE - 1)) begin
          press_rep[i] = 1'b1;
          rep_cnt_d[i] = '0;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_first_q <= '1;
      for (int i = 0; i < N_BTN; i++) rep_cnt_q[i] <= '0;
    end else begin
      rep_first_q <= rep_first_d;
      for (int i = 0; i < N_BTN; i++) rep_cnt_q[i] <= rep_cnt_d[i];
    end
  end

  assign press = press_deb | press_rep;
`else
  assign press = press_deb;
`endif

  always_comb begin
    logic [IDW-1:0] cand;
    int             j;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_BTN; k++) begin
      j = int'(rr_q) + k;
      if (j >= N_BTN) j = j - N_BTN;
      cand = IDW'(j);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    rr_d      = rr_q;
    grant_now = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          grant_now = 1'b1;
          id_d      = grant_idx;
          rr_d      = (grant_idx == IDW'(N_BTN - 1)) ? '0 : grant_idx + 1'b1;
          state_d   = S_VALID;
        end
      end
      S_VALID: begin
        if (evt.evt_ready) state_d = S_IDLE;
      end
    endcase
  end

  // A press landing on the grant cycle of the same button re-arms pending without overflow.
  assign grant_vec = grant_now ? (N_BTN'(1) << grant_idx) : '0;
  assign pending_d = (pending_q & ~grant_vec) | press;
  assign ovf_d     = (ovf_q & ~ovf_clr_i) | (|(press & pending_q & ~grant_vec));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      pending_q <= '0;
      presc_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= S_IDLE;
      id_q      <= '0;
      rr_q      <= '0;
      for (int i = 0; i < N_BTN; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      pending_q <= pending_d;
      presc_q   <= presc_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      id_q      <= id_d;
      rr_q      <= rr_d;
      for (int i = 0; i < N_BTN; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  assign btn_level_o   = level_q;
  assign ovf_o         = ovf_q;
  assign evt.evt_valid = (state_q == S_VALID);
  assign evt.evt_id    = id_q;
endmodule
`default_nettype wire
